// File: rtl/cosim_commit_serializer.sv
// cosim_commit_serializer
// Captures up to COMMIT_WIDTH retired instructions plus an optional trap event
// per cycle, packs them in program order into a circular buffer, and replays
// them one entry per cycle on a ready/valid trace port.
// Optional feature macro: COSIM_SERIALIZER_DROP_CNT_EN adds a saturating
// drop_cnt output counting events offered while in_ready is low.
module cosim_commit_serializer #(
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = 64,
  parameter int DEPTH        = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_pc,
  input  logic [32*COMMIT_WIDTH-1:0]   in_inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0] in_mstatus,
  input  logic [COMMIT_WIDTH-1:0]      in_check,
  input  logic                         in_int_xcpt,
  input  logic [XLEN-1:0]              in_cause,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_wdata,
  output logic [XLEN-1:0]              out_mstatus,
  output logic [XLEN-1:0]              out_cause,
  output logic [31:0]                  out_inst,
  output logic                         out_check,
  output logic                         out_is_trap
`ifdef COSIM_SERIALIZER_DROP_CNT_EN
  ,
  output logic [31:0]                  drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] mstatus;
    logic            check;
    logic            is_trap;
    logic [XLEN-1:0] cause;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] n_valid;
  logic [CNT_W-1:0] push_n;
  logic [PTR_W-1:0] lane_idx [COMMIT_WIDTH];
  logic [PTR_W-1:0] trap_idx;
  entry_t           lane_entry [COMMIT_WIDTH];
  entry_t           trap_entry;
  entry_t           head;
  logic [CNT_W-1:0] free_space;
  logic             in_fire;
  logic             pop;

  // Compaction: each valid lane lands at wr_ptr plus the number of valid lanes below it.
  always_comb begin
    // NOTE: blocking assignments here form a running prefix sum inside one
    // combinational evaluation; in always_ff they would imply extra registers.
    n_valid = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_idx[i]           = wr_ptr_q + n_valid[PTR_W-1:0];
      n_valid               = n_valid + CNT_W'(in_valid[i]);
      lane_entry[i].pc      = in_pc[i*XLEN +: XLEN];
      lane_entry[i].inst    = in_inst[i*32 +: 32];
      lane_entry[i].wdata   = in_wdata[i*XLEN +: XLEN];
      lane_entry[i].mstatus = in_mstatus[i*XLEN +: XLEN];
      lane_entry[i].check   = in_check[i];
      lane_entry[i].is_trap = 1'b0;
      lane_entry[i].cause   = '0;
    end
    trap_idx           = wr_ptr_q + n_valid[PTR_W-1:0];
    push_n             = n_valid + CNT_W'(in_int_xcpt);
    trap_entry         = '0;
    trap_entry.is_trap = 1'b1;
    trap_entry.cause   = in_cause;
  end

  // Flow control: ready only while a full bundle plus a trap still fits.
  assign free_space = CNT_W'(DEPTH) - count_q;
  assign in_ready   = free_space >= CNT_W'(COMMIT_WIDTH + 1);
  assign out_valid  = count_q != '0;
  assign in_fire    = in_ready && ((|in_valid) || in_int_xcpt);
  assign pop        = out_valid && out_ready;

  // Next-state pointers and occupancy; push and pop in one cycle both apply.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (in_fire ? push_n[PTR_W-1:0] : '0);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (in_fire ? push_n : '0) - CNT_W'(pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: lane entries in ascending order, trap entry appended last.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the storage array is reset on purpose so the head fields read as
    // zero after reset; this forces flops rather than a RAM macro.
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
    end else if (in_fire) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (in_valid[i]) mem_q[lane_idx[i]] <= lane_entry[i];
      end
      if (in_int_xcpt) mem_q[trap_idx] <= trap_entry;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_pc      = head.pc;
  assign out_inst    = head.inst;
  assign out_wdata   = head.wdata;
  assign out_mstatus = head.mstatus;
  assign out_check   = head.check;
  assign out_is_trap = head.is_trap;
  assign out_cause   = head.cause;

`ifdef COSIM_SERIALIZER_DROP_CNT_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [32:0] drop_sum;

  // Saturating count of events offered while the buffer refuses input.
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 33'(push_n);
    drop_cnt_d = drop_cnt_q;
    if (!in_ready) drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
  end

  // Drop counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cosim_commit_serializer.sv
// Self-checking bench for cosim_commit_serializer: directed scenarios followed
// by random traffic, all compared against an in-order queue model.
module tb_cosim_commit_serializer;

  localparam int CW    = 2;
  localparam int XLEN  = 64;
  localparam int DEPTH = 16;

  logic               clock;
  logic               reset;
  logic [CW-1:0]      in_valid;
  logic [XLEN*CW-1:0] in_pc;
  logic [32*CW-1:0]   in_inst;
  logic [XLEN*CW-1:0] in_wdata;
  logic [XLEN*CW-1:0] in_mstatus;
  logic [CW-1:0]      in_check;
  logic               in_int_xcpt;
  logic [XLEN-1:0]    in_cause;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc, out_wdata, out_mstatus, out_cause;
  logic [31:0]        out_inst;
  logic               out_check;
  logic               out_is_trap;
`ifdef COSIM_SERIALIZER_DROP_CNT_EN
  logic [31:0]        drop_cnt;
`endif

  cosim_commit_serializer #(.COMMIT_WIDTH(CW), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .in_wdata    (in_wdata),
    .in_mstatus  (in_mstatus),
    .in_check    (in_check),
    .in_int_xcpt (in_int_xcpt),
    .in_cause    (in_cause),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_wdata   (out_wdata),
    .out_mstatus (out_mstatus),
    .out_cause   (out_cause),
    .out_inst    (out_inst),
    .out_check   (out_check),
    .out_is_trap (out_is_trap)
`ifdef COSIM_SERIALIZER_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] wdata;
    logic [63:0] mstatus;
    logic        check;
    logic        is_trap;
    logic [63:0] cause;
  } trace_t;

  trace_t      model_q[$];
  int unsigned total_pushed;
  longint      drop_model;
  int          total;
  int          bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (DEPTH - model_q.size()) >= CW + 1;
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, model_q.size() != 0);
    check("in_ready", in_ready, model_ready());
    if (model_q.size() != 0) begin
      check("out_pc", out_pc, model_q[0].pc);
      check("out_inst", out_inst, model_q[0].inst);
      check("out_wdata", out_wdata, model_q[0].wdata);
      check("out_mstatus", out_mstatus, model_q[0].mstatus);
      check("out_check", out_check, model_q[0].check);
      check("out_is_trap", out_is_trap, model_q[0].is_trap);
      check("out_cause", out_cause, model_q[0].cause);
    end
`ifdef COSIM_SERIALIZER_DROP_CNT_EN
    check("drop_cnt", drop_cnt, drop_model);
`endif
  endtask

  // Drive a new offer with random payload; called at the falling edge.
  task automatic set_inputs(input logic [CW-1:0] v, input logic x, input logic ordy);
    for (int i = 0; i < CW; i++) begin
      in_pc[i*XLEN +: XLEN]      = {$urandom, $urandom};
      in_wdata[i*XLEN +: XLEN]   = {$urandom, $urandom};
      in_mstatus[i*XLEN +: XLEN] = {$urandom, $urandom};
      in_inst[i*32 +: 32]        = $urandom;
    end
    in_check    = CW'($urandom);
    in_cause    = {$urandom, $urandom};
    in_valid    = v;
    in_int_xcpt = x;
    out_ready   = ordy;
  endtask

  // One clock: predict acceptance from the model, advance the model, compare.
  task automatic step();
    bit     fire, pop;
    trace_t e;
    fire = model_ready() && ((|in_valid) || in_int_xcpt);
    pop  = (model_q.size() != 0) && out_ready;
    if (!model_ready()) begin
      drop_model = drop_model + $countones(in_valid) + int'(in_int_xcpt);
      if (drop_model > 64'hFFFF_FFFF) drop_model = 64'hFFFF_FFFF;
    end
    @(posedge clock);
    if (pop) void'(model_q.pop_front());
    if (fire) begin
      for (int i = 0; i < CW; i++) begin
        if (in_valid[i]) begin
          e.pc      = in_pc[i*XLEN +: XLEN];
          e.inst    = in_inst[i*32 +: 32];
          e.wdata   = in_wdata[i*XLEN +: XLEN];
          e.mstatus = in_mstatus[i*XLEN +: XLEN];
          e.check   = in_check[i];
          e.is_trap = 1'b0;
          e.cause   = '0;
          model_q.push_back(e);
          total_pushed++;
        end
      end
      if (in_int_xcpt) begin
        e         = '{default: '0};
        e.is_trap = 1'b1;
        e.cause   = in_cause;
        model_q.push_back(e);
        total_pushed++;
      end
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && model_q.size() != 0; k++) begin
      set_inputs('0, 1'b0, 1'b1);
      step();
    end
    check("drain_empty", out_valid, 1'b0);
  endtask

  initial begin
    logic [63:0] pa, pb, wrap_last [$];
    total = 0; bad = 0; total_pushed = 0; drop_model = 0;
    reset = 1'b1;
    set_inputs('0, 1'b0, 1'b0);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_pc", out_pc, 64'h0);
    check("rst_out_is_trap", out_is_trap, 1'b0);
    check("rst_out_cause", out_cause, 64'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Sparse compaction: only lane 1 valid.
    set_inputs(2'b10, 1'b0, 1'b1);
    in_pc[2*XLEN-1 -: XLEN] = 64'h8000_0004;
    step();
    check("sparse_pc", out_pc, 64'h8000_0004);
    check("sparse_valid", out_valid, 1'b1);
    set_inputs('0, 1'b0, 1'b1);
    step();
    check("sparse_empty", out_valid, 1'b0);

    // Full bundle plus trap, then three pops.
    set_inputs(2'b11, 1'b1, 1'b0);
    in_pc    = {64'h104, 64'h100};
    in_cause = 64'h8000_0000_0000_0007;
    step();
    check("bundle_pc0", out_pc, 64'h100);
    set_inputs('0, 1'b0, 1'b1);
    step();
    check("bundle_pc1", out_pc, 64'h104);
    set_inputs('0, 1'b0, 1'b1);
    step();
    check("bundle_trap", out_is_trap, 1'b1);
    check("bundle_cause", out_cause, 64'h8000_0000_0000_0007);
    check("bundle_trap_pc", out_pc, 64'h0);
    set_inputs('0, 1'b0, 1'b1);
    step();

    // Backpressure: 2 lanes per cycle with no pops.
    for (int k = 1; k <= 9; k++) begin
      set_inputs(2'b11, 1'b0, 1'b0);
      step();
      check("bp_in_ready", in_ready, k < 7);
    end
`ifdef COSIM_SERIALIZER_DROP_CNT_EN
    check("bp_drop_cnt", drop_cnt, 32'd4);
`endif
    drain();

    // Wrap-around: align write index to DEPTH-1, then push two lanes.
    for (int k = 0; k < DEPTH && (total_pushed % DEPTH) != DEPTH - 1; k++) begin
      set_inputs(2'b01, 1'b0, 1'b1);
      step();
    end
    check("wrap_align", total_pushed % DEPTH, DEPTH - 1);
    set_inputs(2'b11, 1'b0, 1'b1);
    pa = 64'hAAAA_0000_0000_000F;
    pb = 64'hBBBB_0000_0000_0000;
    in_pc = {pb, pa};
    step();
    for (int k = 0; k < 2 * DEPTH && model_q.size() != 0; k++) begin
      wrap_last.push_back(out_pc);
      set_inputs('0, 1'b0, 1'b1);
      step();
    end
    check("wrap_count", wrap_last.size() >= 2, 1'b1);
    if (wrap_last.size() >= 2) begin
      check("wrap_first", wrap_last[wrap_last.size()-2], pa);
      check("wrap_second", wrap_last[wrap_last.size()-1], pb);
    end

    // Simultaneous push and pop with one entry held.
    set_inputs(2'b01, 1'b0, 1'b0);
    step();
    set_inputs(2'b10, 1'b0, 1'b1);
    pa = 64'hC0DE_0000_0000_1234;
    in_pc[2*XLEN-1 -: XLEN] = pa;
    step();
    check("simul_valid", out_valid, 1'b1);
    check("simul_pc", out_pc, pa);
    drain();

    // Async reset mid-cycle with five entries held.
    set_inputs(2'b11, 1'b0, 1'b0); step();
    set_inputs(2'b11, 1'b0, 1'b0); step();
    set_inputs(2'b01, 1'b0, 1'b0); step();
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_pc", out_pc, 64'h0);
    model_q.delete();
    drop_model = 0;
    @(negedge clock);
    reset = 1'b0;
    set_inputs(2'b01, 1'b0, 1'b1);
    pa = 64'h0000_0000_DEAD_BEEF;
    in_pc[XLEN-1:0] = pa;
    step();
    check("arst_post_valid", out_valid, 1'b1);
    check("arst_post_pc", out_pc, pa);

    // Random traffic with phases of heavy backpressure.
    for (int k = 0; k < 600; k++) begin
      logic ordy;
      ordy = ((k % 100) < 30) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      set_inputs(CW'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, ordy);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
